// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    // Encoding is fixed; the unused code 2'd3 falls back to IDLE in the FSM.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit counter width: ceil(log2(w)), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, time-shared by the serial adder sequencer.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic C_in,
    output logic S_out,
    output logic C_out
);

    assign S_out = A ^ B ^ C_in;
    assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell iterated LSB first over WIDTH bits,
// with a carry flip-flop closing the loop and a start/done handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             C_out,
    output logic             OVF
);

    localparam int unsigned      CNT_W    = unsigned'(cnt_width(int'(WIDTH)));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               cy_q,     cy_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic               c_out_q,  c_out_d;
    logic               ovf_q,    ovf_d;
    logic               ready_q,  ready_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               cell_s;
    logic               cell_c;

    full_adder u_cell (
        .A     (a_sh_q[0]),
        .B     (b_sh_q[0]),
        .C_in  (cy_q),
        .S_out (cell_s),
        .C_out (cell_c)
    );

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cy_d    = C_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cy_d                = cell_c;
                sum_sh_d            = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1]   = cell_s;
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                cnt_d               = cnt_q + CNT_W'(1);
                // On the MSB step cy_q is the carry into the MSB.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_sh_d;
                    c_out_d = cell_c;
                    ovf_d   = cy_q ^ cell_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_RUN) || (state_d == S_DONE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign SUM   = sum_q;
    assign C_out = c_out_q;
    assign OVF   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder_ctrl;

    typedef struct {
        int sum;
        int cout;
        int ovf;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start1, cin1;
    logic [0:0] a1, b1;
    logic       ready1, busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    exp_t q8[$];
    exp_t q1[$];
    int   done_cyc8[$];
    int   done_sum8[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .start(start8), .A(a8), .B(b8), .C_in(cin8),
        .ready(ready8), .busy(busy8), .done(done8),
        .SUM(sum8), .C_out(cout8), .OVF(ovf8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST(rst), .start(start1), .A(a1), .B(b1), .C_in(cin1),
        .ready(ready1), .busy(busy1), .done(done1),
        .SUM(sum1), .C_out(cout1), .OVF(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: w-bit add as plain integer arithmetic; overflow from operand/result signs.
    function automatic exp_t model(input int w, input int a, input int b, input int c, input int k);
        exp_t e;
        int   full;
        int   sa, sb, ss;
        full   = a + b + c;
        e.sum  = full % (1 << w);
        e.cout = (full >> w) & 1;
        sa     = (a >> (w - 1)) & 1;
        sb     = (b >> (w - 1)) & 1;
        ss     = (e.sum >> (w - 1)) & 1;
        e.ovf  = ((sa == sb) && (ss != sa)) ? 1 : 0;
        e.cyc  = k;
        return e;
    endfunction

    // Acceptance tracker: a request is taken on an edge where start and ready are both high.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            q8.delete();
            q1.delete();
        end else begin
            if (start8 === 1'b1 && ready8 === 1'b1)
                q8.push_back(model(8, int'(a8), int'(b8), int'(cin8), cyc));
            if (start1 === 1'b1 && ready1 === 1'b1)
                q1.push_back(model(1, int'(a1), int'(b1), int'(cin1), cyc));
        end
        cyc++;
    end

    // Result monitors.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("done8_without_request", done8, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("sum8", sum8, e.sum);
                check("cout8", cout8, e.cout);
                check("ovf8", ovf8, e.ovf);
                check("latency8", cyc - e.cyc, 9);
                done_cyc8.push_back(cyc);
                done_sum8.push_back(int'(sum8));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("done1_without_request", done1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("sum1", sum1, e.sum);
                check("cout1", cout1, e.cout);
                check("ovf1", ovf1, e.ovf);
                check("latency1", cyc - e.cyc, 2);
            end
        end
    end

    task automatic wait_ready8();
        for (int i = 0; i < 40 && ready8 !== 1'b1; i++) @(negedge clk);
        check("ready8_wait", ready8, 1);
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 40 && (q8.size() != 0 || ready8 !== 1'b1); i++) @(negedge clk);
        check("drain8", q8.size(), 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_ready8();
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        check("ready8_low_in_run", ready8, 0);
        check("busy8_in_run", busy8, 1);
        wait_idle8();
    endtask

    task automatic op1(input logic a, input logic b, input logic c);
        for (int i = 0; i < 10 && ready1 !== 1'b1; i++) @(negedge clk);
        check("ready1_wait", ready1, 1);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 10 && (q1.size() != 0 || ready1 !== 1'b1); i++) @(negedge clk);
        check("drain1", q1.size(), 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_ready8", ready8, 1);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_ready1", ready1, 1);
        rst = 1'b0;

        // start held high while operands churn during RUN
        done_cyc8.delete();
        done_sum8.delete();
        wait_ready8();
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ready8 !== 1'b1) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
        end
        start8 = 1'b0;
        wait_idle8();
        check("held_done_count_ge2", (done_cyc8.size() >= 2) ? 1 : 0, 1);
        if (done_cyc8.size() >= 2) begin
            check("held_first_sum", done_sum8[0], 8'h33);
            check("held_spacing", done_cyc8[1] - done_cyc8[0], 10);
        end

        op8(8'h5A, 8'h3C, 1'b0);
        check("sum_5a_3c", sum8, 8'h96);
        check("cout_5a_3c", cout8, 0);
        check("ovf_5a_3c", ovf8, 1);
        op8(8'hFF, 8'h01, 1'b0);
        check("sum_ff_01", sum8, 8'h00);
        check("cout_ff_01", cout8, 1);
        check("ovf_ff_01", ovf8, 0);
        op8(8'h7F, 8'h00, 1'b1);
        check("sum_7f_00_c", sum8, 8'h80);
        check("cout_7f_00_c", cout8, 0);
        check("ovf_7f_00_c", ovf8, 1);

        // reset after three RUN edges abandons the operation
        wait_ready8();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_sum8", sum8, 0);
        check("midrst_cout8", cout8, 0);
        check("midrst_ovf8", ovf8, 0);
        check("midrst_ready8", ready8, 1);
        check("midrst_busy8", busy8, 0);
        check("midrst_done8", done8, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen = seen | done8;
        end
        check("no_done_after_rst", seen, 0);
        op8(8'h10, 8'h20, 1'b0);
        check("sum_after_rst", sum8, 8'h30);

        // WIDTH=1 truth table
        for (int k = 0; k < 8; k++) begin
            op1(k[2], k[1], k[0]);
            check("w1_sum", sum1, k[2] ^ k[1] ^ k[0]);
            check("w1_cout", cout1, (k[2] + k[1] + k[0]) >= 2 ? 1 : 0);
        end

        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("final_q8_empty", q8.size(), 0);
        check("final_q1_empty", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
